md_hilo_ctrl: RTL and testbench

Sequencer for the multi-cycle multiply/divide unit and the architectural HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and runs iterative arithmetic over a fixed number of cycles. It drives `isbusy`, which the stall unit combines with `RHL_visit` to freeze PC/IF/ID while a HI/LO consumer would read a stale value. It sits beside the EX stage and shares the pipeline's advance (`EX_MEM1Wr`) and flush (`MEM1_ex | MEM1_eret_flush`) controls.

---
 rtl/md_hilo_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_md_hilo_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_hilo_ctrl.sv
// md_hilo_ctrl: multiply/divide sequencer and architectural HI/LO pair.
// Optional macro MD_FAST_MUL_EN selects a single-cycle multiplier for MULT/MULTU.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   EX_MDOp[2:0]       0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 none
//   EX_A, EX_B         rs / rt operands after bypass
//   EX_MEM1Wr          EX stage advances this cycle
//   MEM1_flush         exception or ERET flush in MEM1
//   isbusy             unit occupied, or accepting a multi-cycle op this cycle
//   HI, LO             architectural HI/LO registers
module md_hilo_ctrl #(
    parameter int MD_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  EX_MDOp,
    input  logic [31:0] EX_A,
    input  logic [31:0] EX_B,
    input  logic        EX_MEM1Wr,
    input  logic        MEM1_flush,
    output logic        isbusy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t      state;
    logic [4:0]  cnt;

    // MUL: r_acc = partial product, r_a = shifting multiplicand,
    //      r_b = shifting multiplier.
    // DIV: r_acc = {remainder, dividend/quotient}, r_b = divisor,
    //      r_a[31:0] = raw dividend for the divide-by-zero result.
    logic [63:0] r_acc;
    logic [63:0] r_a;
    logic [31:0] r_b;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;

    logic        op_ok;
    logic        is_mul;
    logic        is_div;
    logic        is_sgn;
    logic        acc;
    logic        last;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    logic [63:0] prod_nx;
    logic [63:0] prod_fix;
    logic [32:0] sh;
    logic [32:0] diff;
    logic        ge;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;
    logic [31:0] rem_fix;
    logic [31:0] quo_fix;

    assign op_ok  = (EX_MDOp != 3'd0) && (EX_MDOp != 3'd7);
    assign is_mul = (EX_MDOp == 3'd1) || (EX_MDOp == 3'd2);
    assign is_div = (EX_MDOp == 3'd3) || (EX_MDOp == 3'd4);
    assign is_sgn = (EX_MDOp == 3'd1) || (EX_MDOp == 3'd3);

    assign acc = op_ok && EX_MEM1Wr && !MEM1_flush
                 && (state == S_IDLE);

    // Combinational so an ID-stage HI/LO reader stalls in the accept cycle.
    assign isbusy = (state != S_IDLE) || (acc && (is_mul || is_div));

    assign a_mag = (is_sgn && EX_A[31]) ? (32'd0 - EX_A) : EX_A;
    assign b_mag = (is_sgn && EX_B[31]) ? (32'd0 - EX_B) : EX_B;

    assign last = (cnt == 5'(MD_ITER - 1));

    // One shift-add step.
    assign prod_nx  = r_acc + (r_b[0] ? r_a : 64'd0);
    assign prod_fix = neg_q ? (64'd0 - prod_nx) : prod_nx;

    // One restoring-division step; no borrow out of diff means sh >= divisor.
    assign sh      = {r_acc[63:32], r_acc[31]};
    assign diff    = sh - {1'b0, r_b};
    assign ge      = !diff[32];
    assign rem_nx  = ge ? diff[31:0] : sh[31:0];
    assign quo_nx  = {r_acc[30:0], ge};
    assign quo_fix = neg_q ? (32'd0 - quo_nx) : quo_nx;
    assign rem_fix = neg_r ? (32'd0 - rem_nx) : rem_nx;

`ifdef MD_FAST_MUL_EN
    logic [63:0] fast_p;
    logic [63:0] fast_fix;

    assign fast_p   = {32'd0, a_mag} * {32'd0, b_mag};
    assign fast_fix = (is_sgn && (EX_A[31] ^ EX_B[31]))
                      ? (64'd0 - fast_p) : fast_p;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 5'd0;
            HI       <= 32'd0;
            LO       <= 32'd0;
            r_acc    <= 64'd0;
            r_a      <= 64'd0;
            r_b      <= 32'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    cnt <= 5'd0;
                    if (acc) begin
                        neg_q    <= is_sgn && (EX_A[31] ^ EX_B[31]);
                        neg_r    <= is_sgn && EX_A[31];
                        div_zero <= (EX_B == 32'd0);
                        unique case (1'b1)
                            is_mul: begin
`ifdef MD_FAST_MUL_EN
                                {HI, LO} <= fast_fix;
`else
                                state <= S_MUL;
                                r_acc <= 64'd0;
                                r_a   <= {32'd0, a_mag};
                                r_b   <= b_mag;
`endif
                            end
                            is_div: begin
                                state <= S_DIV;
                                r_acc <= {32'd0, a_mag};
                                r_a   <= {32'd0, EX_A};
                                r_b   <= b_mag;
                            end
                            (EX_MDOp == 3'd5): HI <= EX_A;
                            (EX_MDOp == 3'd6): LO <= EX_A;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    r_acc <= prod_nx;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    cnt   <= cnt + 5'd1;
                    if (last) begin
                        {HI, LO} <= prod_fix;
                        state    <= S_IDLE;
                        cnt      <= 5'd0;
                    end
                end
                S_DIV: begin
                    r_acc <= {rem_nx, quo_nx};
                    cnt   <= cnt + 5'd1;
                    if (last) begin
                        state <= S_IDLE;
                        cnt   <= 5'd0;
                        if (div_zero) begin
                            LO <= 32'hFFFF_FFFF;
                            HI <= r_a[31:0];
                        end else begin
                            LO <= quo_fix;
                            HI <= rem_fix;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// tb_md_hilo_ctrl: self-checking bench for md_hilo_ctrl.
// Table vectors, hand-written gating/reset sequences, random ops vs a model.
module tb_md_hilo_ctrl;

    logic        clk;
    logic        rst;
    logic [2:0]  EX_MDOp;
    logic [31:0] EX_A;
    logic [31:0] EX_B;
    logic        EX_MEM1Wr;
    logic        MEM1_flush;
    logic        isbusy;
    logic [31:0] HI;
    logic [31:0] LO;

    md_hilo_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .EX_MDOp    (EX_MDOp),
        .EX_A       (EX_A),
        .EX_B       (EX_B),
        .EX_MEM1Wr  (EX_MEM1Wr),
        .MEM1_flush (MEM1_flush),
        .isbusy     (isbusy),
        .HI         (HI),
        .LO         (LO)
    );

`ifdef MD_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 32;
`endif
    localparam int DIV_LAT = 32;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t        tbl[13];
    int          n_vec;
    int          n_mis;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic bit md_op(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    function automatic int exp_lat(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return MUL_LAT;
        if (op == 3'd3 || op == 3'd4) return DIV_LAT;
        return 0;
    endfunction

    // Reference: plain arithmetic on the architectural meaning of each op.
    task automatic model(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin
                q = sa * sb;
                p = q;
                {m_hi, m_lo} = p;
            end
            3'd2: begin
                p = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = p;
            end
            3'd3, 3'd4: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else if (op == 3'd3) begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one op for one cycle, then count busy cycles after accept.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        int n;
        @(negedge clk);
        EX_MDOp    = op;
        EX_A       = a;
        EX_B       = b;
        EX_MEM1Wr  = 1'b1;
        MEM1_flush = 1'b0;
        #1;
        chk("busy_accept", 64'(isbusy), 64'(md_op(op)));
        @(negedge clk);
        EX_MDOp = 3'd0;
        #1;
        n = 0;
        while (isbusy && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("latency", 64'(n), 64'(exp_lat(op)));
    endtask

    initial begin
        int n;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        n_vec = 0;
        n_mis = 0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;

        tbl[0]  = '{3'd4, 32'd100, 32'd7, 32'd2, 32'd14};
        tbl[1]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,
                    32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[2]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF,
                    32'h0, 32'h8000_0000};
        tbl[3]  = '{3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF};
        tbl[4]  = '{3'd3, 32'hFFFF_FFFB, 32'd0,
                    32'hFFFF_FFFB, 32'hFFFF_FFFF};
        tbl[5]  = '{3'd4, 32'd7, 32'd100, 32'd7, 32'd0};
        tbl[6]  = '{3'd1, 32'hFFFF_FFFF, 32'd3,
                    32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[7]  = '{3'd2, 32'hFFFF_FFFF, 32'd3, 32'd2, 32'hFFFF_FFFD};
        tbl[8]  = '{3'd5, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFD};
        tbl[9]  = '{3'd6, 32'h5678, 32'd0, 32'h1234, 32'h5678};
        tbl[10] = '{3'd7, 32'hAAAA, 32'hBBBB, 32'h1234, 32'h5678};
        tbl[11] = '{3'd1, 32'h8000_0000, 32'h8000_0000,
                    32'h4000_0000, 32'h0};
        tbl[12] = '{3'd3, 32'h8000_0001, 32'd7,
                    32'hFFFF_FFFF, 32'hEDB6_DB6E};

        rst        = 1'b1;
        EX_MDOp    = 3'd0;
        EX_A       = 32'd0;
        EX_B       = 32'd0;
        EX_MEM1Wr  = 1'b1;
        MEM1_flush = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_busy", 64'(isbusy), 64'd0);
        chk("reset_hi", 64'(HI), 64'd0);
        chk("reset_lo", 64'(LO), 64'd0);

        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b);
            chk($sformatf("tbl%0d_hi", i), 64'(HI), 64'(tbl[i].hi));
            chk($sformatf("tbl%0d_lo", i), 64'(LO), 64'(tbl[i].lo));
            m_hi = tbl[i].hi;
            m_lo = tbl[i].lo;
        end

        // DIVU held by a stall for 3 cycles: must start only once.
        @(negedge clk);
        EX_MDOp   = 3'd4;
        EX_A      = 32'd100;
        EX_B      = 32'd7;
        EX_MEM1Wr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_busy", 64'(isbusy), 64'd0);
            @(negedge clk);
        end
        EX_MEM1Wr = 1'b1;
        #1;
        chk("stall_accept", 64'(isbusy), 64'd1);
        @(negedge clk);
        EX_MDOp = 3'd0;
        #1;
        n = 0;
        while (isbusy && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("stall_lat", 64'(n), 64'd32);
        chk("stall_res", {HI, LO}, {32'd2, 32'd14});
        repeat (3) @(negedge clk);
        #1;
        chk("stall_once", 64'(isbusy), 64'd0);
        m_hi = 32'd2;
        m_lo = 32'd14;

        // Flushed DIV is never accepted.
        @(negedge clk);
        EX_MDOp    = 3'd3;
        EX_A       = 32'd55;
        EX_B       = 32'd4;
        MEM1_flush = 1'b1;
        #1;
        chk("flush_busy0", 64'(isbusy), 64'd0);
        @(negedge clk);
        EX_MDOp    = 3'd0;
        MEM1_flush = 1'b0;
        #1;
        chk("flush_busy1", 64'(isbusy), 64'd0);
        chk("flush_hilo", {HI, LO}, {m_hi, m_lo});

        // MTLO arriving during a running DIV is ignored.
        @(negedge clk);
        EX_MDOp = 3'd3;
        EX_A    = 32'd100;
        EX_B    = 32'd7;
        @(negedge clk);
        EX_MDOp = 3'd0;
        #1;
        n = 0;
        while (isbusy && n < 100) begin
            if (n == 5) begin
                EX_MDOp = 3'd6;
                EX_A    = 32'hDEAD;
            end else begin
                EX_MDOp = 3'd0;
            end
            @(negedge clk);
            #1;
            n++;
        end
        EX_MDOp = 3'd0;
        chk("mtlo_busy_lat", 64'(n), 64'd32);
        chk("mtlo_busy_res", {HI, LO}, {32'd2, 32'd14});

        // Reset during iteration 10 of a DIV.
        @(negedge clk);
        EX_MDOp = 3'd3;
        EX_A    = 32'd1000;
        EX_B    = 32'd3;
        @(negedge clk);
        EX_MDOp = 3'd0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(isbusy), 64'd0);
        chk("rst_mid_hilo", {HI, LO}, 64'd0);
        run_op(3'd2, 32'd6, 32'd7);
        chk("rst_multu", {HI, LO}, {32'd0, 32'd42});
        m_hi = 32'd0;
        m_lo = 32'd42;

        // Random ops against the arithmetic model.
        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom_range(1, 6));
            a  = $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
            run_op(op, a, b);
            model(op, a, b);
            chk($sformatf("rnd%0d_op%0d_hi", k, op), 64'(HI), 64'(m_hi));
            chk($sformatf("rnd%0d_op%0d_lo", k, op), 64'(LO), 64'(m_lo));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_mis);
        $finish;
    end

endmodule
